spi_slave_regfile: RTL and testbench

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

---
 rtl/spi_slave_regfile_if.sv | 33 +++
 rtl/spi_slave_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_if.sv
// rtl/spi_slave_regfile_if.sv - SPI pins and local read port of spi_slave_regfile
//
// Purpose: bundles the SPI pins and the local register read port.
// Signals:
//   spi_clk  SPI clock from master (mode 0), asynchronous to sys_clk
//   cs       chip select, active low, asynchronous
//   mosi     serial data master->slave, MSB first
//   miso     serial data slave->master, MSB first, registered
//   loc_addr local read-port address
//   loc_data combinational read data for loc_addr
//   wr_pulse one-cycle strobe per committed SPI write
//   busy     high while synchronized cs is low
// Modports: slave (the register file), master (SPI master / local reader).
interface spi_slave_regfile_if;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [2:0] loc_addr;
    logic [7:0] loc_data;
    logic       wr_pulse;
    logic       busy;

    modport slave (
        input  spi_clk, cs, mosi, loc_addr,
        output miso, loc_data, wr_pulse, busy
    );

    modport master (
        output spi_clk, cs, mosi, loc_addr,
        input  miso, loc_data, wr_pulse, busy
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 slave in front of a 7-entry register file plus write counter
//
// Purpose: oversamples an SPI mode-0 bus on sys_clk and services 16-clock
// transactions {rw,4'b0,addr[2:0]} + data byte. Regs 0-6 are read/write,
// addr 7 reads the committed-write counter (wcount) and ignores writes.
// Ports:
//   sys_clk  system clock, all logic on rising edge
//   rst      synchronous active-high reset
//   bus      spi_slave_regfile_if.slave (SPI pins, local read port, wr_pulse, busy)
module spi_slave_regfile #(
    parameter int CLK_DIV_MIN = 8
) (
    input  logic               sys_clk,
    input  logic               rst,
    spi_slave_regfile_if.slave bus
);

    if (CLK_DIV_MIN < 2) begin : g_param_check
        $error("CLK_DIV_MIN must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic        r_cs_meta, r_cs_sync, r_cs_prev;
    logic        r_mosi_meta, r_mosi_sync;
    logic [1:0]  r_sync_vld;
    logic        r_cs_armed;

    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_rw;
    logic [2:0]  r_addr;
    logic [7:0]  r_regs [0:6];
    logic [7:0]  r_wcount;
    logic        r_wr_pulse;
    logic        r_miso;

    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic        w_last_bit;
    logic [7:0]  w_rx_shift;
    logic [2:0]  w_cmd_addr;
    logic [7:0]  w_cmd_rd;
    logic [7:0]  w_loc_data;
    logic        w_commit;
    logic        w_miso_d;

    // Synchronizers. r_sync_vld marks when r_cs_sync holds a real pin sample
    // rather than its reset value; cs must be seen high after that before a
    // falling edge may start a transaction, so a transfer already in flight
    // when rst is released is never decoded.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_sync_vld  <= 2'b00;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sclk_meta <= bus.spi_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= bus.cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= bus.mosi;
            r_mosi_sync <= r_mosi_meta;
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_cs_sync) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
    assign w_cs_fall   = r_cs_armed & r_cs_prev & ~r_cs_sync;
    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_rx_shift  = {r_rx[6:0], r_mosi_sync};
    assign w_cmd_addr  = w_rx_shift[2:0];

    always_comb begin
        w_cmd_rd = 8'h00;
        if (w_cmd_addr == 3'd7) begin
            w_cmd_rd = r_wcount;
        end else begin
            w_cmd_rd = r_regs[w_cmd_addr];
        end
    end

    always_comb begin
        w_loc_data = 8'h00;
        if (bus.loc_addr == 3'd7) begin
            w_loc_data = r_wcount;
        end else begin
            w_loc_data = r_regs[bus.loc_addr];
        end
    end

    // FSM: state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. A cs rising edge outranks any spi_clk edge in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_next = S_CMD;
            end
            S_CMD: begin
                if (w_cs_rise)                      w_state_next = S_IDLE;
                else if (w_sclk_rise && w_last_bit) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_cs_rise)                      w_state_next = S_IDLE;
                else if (w_sclk_rise && w_last_bit) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (w_cs_rise) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs (next values of the registered strobes)
    always_comb begin
        w_commit = 1'b0;
        w_miso_d = 1'b0;
        if (r_state == S_DATA && r_rw && w_sclk_rise && w_last_bit &&
            !w_cs_rise && r_addr != 3'd7) begin
            w_commit = 1'b1;
        end
        if (r_state == S_DATA && !r_rw && !r_cs_sync) begin
            w_miso_d = r_tx[7];
        end
    end

    // Datapath. The falling edge that ends the 8th command clock arrives
    // after tx was loaded; it is skipped (bit counter still 0) so bit 7 stays
    // on miso for the master's first data-phase rising edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_rw       <= 1'b0;
            r_addr     <= 3'd0;
            r_wcount   <= 8'h00;
            r_wr_pulse <= 1'b0;
            r_miso     <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_pulse <= w_commit;
            r_miso     <= w_miso_d;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_bit_cnt <= 3'd0;
                        r_rx      <= 8'h00;
                        r_tx      <= 8'h00;
                    end
                end
                S_CMD: begin
                    if (w_sclk_rise && !w_cs_rise) begin
                        r_rx      <= w_rx_shift;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_rw   <= w_rx_shift[7];
                            r_addr <= w_cmd_addr;
                            r_tx   <= w_cmd_rd;
                        end
                    end
                end
                S_DATA: begin
                    if (!w_cs_rise) begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_shift;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_sclk_fall && !r_rw && r_bit_cnt != 3'd0) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
            if (w_commit) begin
                r_regs[r_addr] <= w_rx_shift;
                r_wcount       <= r_wcount + 8'd1;
            end
        end
    end

    assign bus.miso     = r_miso;
    assign bus.wr_pulse = r_wr_pulse;
    assign bus.busy     = ~r_cs_sync;
    assign bus.loc_data = w_loc_data;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb/tb_spi_slave_regfile.sv - self-checking bench for spi_slave_regfile
module tb_spi_slave_regfile;
    localparam int CLK_DIV_MIN = 8;
    localparam int HALF        = CLK_DIV_MIN / 2 + 1;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   pulse_total = 0;
    int   tail_total  = 0;
    logic in_tail = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_slave_regfile_if bus ();

    spi_slave_regfile #(.CLK_DIV_MIN(CLK_DIV_MIN)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always @(negedge sys_clk) begin
        if (bus.wr_pulse === 1'b1) pulse_total++;
        if (in_tail && bus.miso !== 1'b0) tail_total++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic smp);
        bus.mosi = b;
        tick(HALF);
        smp = bus.miso;
        bus.spi_clk = 1'b1;
        tick(HALF);
        bus.spi_clk = 1'b0;
    endtask

    task automatic cs_raise();
        tick(HALF);
        in_tail  = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        tick(HALF + 2);
    endtask

    task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input int nclk,
                            output logic [7:0] rdb, output int pulses, output int tailm,
                            output logic busy_seen);
        int p0, t0;
        logic [23:0] stream;
        logic s;
        p0 = pulse_total;
        t0 = tail_total;
        stream = {b0, b1, 8'h00};
        rdb = 8'h00;
        bus.cs = 1'b0;
        tick(HALF);
        busy_seen = bus.busy;
        for (int i = 0; i < nclk; i++) begin
            in_tail = (i >= 16);
            spi_bit((i < 24) ? stream[23 - i] : 1'b0, s);
            if (i >= 8 && i < 16) rdb = {rdb[6:0], s};
        end
        cs_raise();
        pulses = pulse_total - p0;
        tailm  = tail_total - t0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nclk;
        bit         chk_rd;
        logic [7:0] exp_rd;
        int         exp_pulses;
        logic [2:0] loc_a;
        logic [7:0] exp_loc;
    } vec_t;

    vec_t       vt [9];
    logic [7:0] exp_regs [7];
    int         m_regs [8];
    int         m_wcount;
    logic [7:0] rdb;
    int         pulses, tailm;
    logic       busy_seen, s;

    function automatic int model_read(input int a);
        return (a == 7) ? m_wcount : m_regs[a];
    endfunction

    initial begin
        vt[0] = '{8'h83, 8'hA5, 16, 1'b0, 8'h00, 1, 3'd3, 8'hA5};
        vt[1] = '{8'h03, 8'h00, 16, 1'b1, 8'hA5, 0, 3'd7, 8'h01};
        vt[2] = '{8'h87, 8'hFF, 16, 1'b0, 8'h00, 0, 3'd7, 8'h01};
        vt[3] = '{8'h07, 8'h00, 16, 1'b1, 8'h01, 0, 3'd3, 8'hA5};
        vt[4] = '{8'h82, 8'h3C, 12, 1'b0, 8'h00, 0, 3'd2, 8'h00};
        vt[5] = '{8'h82, 8'h5A, 16, 1'b0, 8'h00, 1, 3'd2, 8'h5A};
        vt[6] = '{8'h02, 8'h00, 16, 1'b1, 8'h5A, 0, 3'd7, 8'h02};
        vt[7] = '{8'h81, 8'h11, 24, 1'b0, 8'h00, 1, 3'd1, 8'h11};
        vt[8] = '{8'h07, 8'h00, 16, 1'b1, 8'h03, 0, 3'd1, 8'h11};
        exp_regs = '{8'h00, 8'h11, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};

        bus.spi_clk  = 1'b0;
        bus.cs       = 1'b1;
        bus.mosi     = 1'b0;
        bus.loc_addr = 3'd0;

        // reset state
        rst = 1'b1;
        tick(4);
        chk("reset miso", bus.miso, 0);
        chk("reset wr_pulse", bus.wr_pulse, 0);
        chk("reset busy", bus.busy, 0);
        for (int a = 0; a < 8; a++) begin
            bus.loc_addr = 3'(a);
            #1;
            chk($sformatf("reset loc_data[%0d]", a), bus.loc_data, 0);
        end
        rst = 1'b0;
        tick(3);

        // directed table
        for (int i = 0; i < 9; i++) begin
            spi_xfer(vt[i].b0, vt[i].b1, vt[i].nclk, rdb, pulses, tailm, busy_seen);
            chk($sformatf("vec%0d busy", i), busy_seen, 1);
            chk($sformatf("vec%0d pulses", i), pulses, vt[i].exp_pulses);
            if (vt[i].chk_rd) chk($sformatf("vec%0d miso byte", i), rdb, vt[i].exp_rd);
            if (vt[i].nclk > 16) chk($sformatf("vec%0d miso after byte1", i), tailm, 0);
            bus.loc_addr = vt[i].loc_a;
            #1;
            chk($sformatf("vec%0d loc_data", i), bus.loc_data, vt[i].exp_loc);
        end
        for (int a = 0; a < 7; a++) begin
            bus.loc_addr = 3'(a);
            #1;
            chk($sformatf("table regs[%0d]", a), bus.loc_data, exp_regs[a]);
        end

        // counter wrap: 256 writes then one more
        do_reset();
        begin
            int ptot;
            ptot = 0;
            for (int i = 0; i < 256; i++) begin
                spi_xfer(8'h80, 8'(i), 16, rdb, pulses, tailm, busy_seen);
                ptot += pulses;
            end
            chk("wrap pulse total", ptot, 256);
        end
        spi_xfer(8'h07, 8'h00, 16, rdb, pulses, tailm, busy_seen);
        chk("wrap spi read wcount", rdb, 8'h00);
        bus.loc_addr = 3'd7;
        #1;
        chk("wrap loc wcount", bus.loc_data, 8'h00);
        spi_xfer(8'h80, 8'h42, 16, rdb, pulses, tailm, busy_seen);
        spi_xfer(8'h07, 8'h00, 16, rdb, pulses, tailm, busy_seen);
        chk("wrap+1 spi read wcount", rdb, 8'h01);
        #1;
        chk("wrap+1 loc wcount", bus.loc_data, 8'h01);

        // reset in the middle of byte1 with cs held low
        begin
            logic [15:0] w;
            int p0, t0, miso_ones;
            w = 16'h85C3;
            p0 = pulse_total;
            miso_ones = 0;
            bus.cs = 1'b0;
            tick(HALF);
            for (int i = 0; i < 12; i++) spi_bit(w[15 - i], s);
            rst = 1'b1;
            tick(2);
            chk("midrst miso", bus.miso, 0);
            chk("midrst wr_pulse", bus.wr_pulse, 0);
            chk("midrst busy", bus.busy, 0);
            bus.loc_addr = 3'd0;
            #1;
            chk("midrst regs[0]", bus.loc_data, 0);
            rst = 1'b0;
            t0 = tail_total;
            in_tail = 1'b1;
            for (int i = 0; i < 12; i++) begin
                spi_bit((i < 4) ? w[3 - i] : 1'b1, s);
                if (s !== 1'b0) miso_ones++;
            end
            in_tail = 1'b0;
            chk("midrst miso samples", miso_ones, 0);
            chk("midrst miso monitor", tail_total - t0, 0);
            cs_raise();
            chk("midrst pulses", pulse_total - p0, 0);
            bus.loc_addr = 3'd5;
            #1;
            chk("midrst regs[5]", bus.loc_data, 0);
            bus.loc_addr = 3'd7;
            #1;
            chk("midrst wcount", bus.loc_data, 0);
            spi_xfer(8'h85, 8'hC3, 16, rdb, pulses, tailm, busy_seen);
            chk("postrst pulses", pulses, 1);
            bus.loc_addr = 3'd5;
            #1;
            chk("postrst regs[5]", bus.loc_data, 8'hC3);
        end

        // randomized transactions against a reference model
        do_reset();
        for (int a = 0; a < 8; a++) m_regs[a] = 0;
        m_wcount = 0;
        for (int t = 0; t < 40; t++) begin
            int a, wr, d, r, nclk, expp, la;
            a  = int'($urandom_range(0, 7));
            wr = int'($urandom_range(0, 1));
            d  = int'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 9));
            nclk = (r < 7) ? 16 : ((r == 7) ? int'($urandom_range(9, 15)) : int'($urandom_range(17, 24)));
            spi_xfer({wr[0], 4'b0000, a[2:0]}, d[7:0], nclk, rdb, pulses, tailm, busy_seen);
            expp = 0;
            if (nclk >= 16) begin
                if (wr == 1) begin
                    if (a != 7) begin
                        m_regs[a] = d;
                        m_wcount = (m_wcount + 1) % 256;
                        expp = 1;
                    end
                end else begin
                    chk($sformatf("rand%0d read addr%0d", t, a), rdb, model_read(a));
                end
                chk($sformatf("rand%0d miso tail", t), tailm, 0);
            end
            chk($sformatf("rand%0d pulses", t), pulses, expp);
            la = int'($urandom_range(0, 7));
            bus.loc_addr = la[2:0];
            #1;
            chk($sformatf("rand%0d loc_data[%0d]", t, la), bus.loc_data, model_read(la));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
